// File: rtl/lsu_pkg.sv
// Shared load/store-unit types and helpers for the store forward queue.
//   sq_state_e  : per-entry store queue state (FREE/ALLOC/READY/CMT)
//   mem_size_e  : access size encoding (byte/half/word)
//   idx_width() : index width for a given queue depth
//   size_to_be(): 4-byte-lane byte-enable mask for an access
package lsu_pkg;

  typedef enum logic [1:0] {
    SQ_FREE  = 2'd0,
    SQ_ALLOC = 2'd1,
    SQ_READY = 2'd2,
    SQ_CMT   = 2'd3
  } sq_state_e;

  typedef enum logic [1:0] {
    MEM_B = 2'b00,
    MEM_H = 2'b01,
    MEM_W = 2'b10
  } mem_size_e;

  function automatic int unsigned idx_width(input int unsigned depth);
    return $clog2(depth);
  endfunction

  // Byte lanes touched within the aligned 4-byte word.
  function automatic logic [3:0] size_to_be(input logic [1:0] addr_lo,
                                            input logic [1:0] size);
    logic [3:0] m;
    case (size)
      MEM_B:   m = 4'b0001;
      MEM_H:   m = 4'b0011;
      default: m = 4'b1111;
    endcase
    return m << addr_lo;
  endfunction

endpackage

// File: rtl/sfq_fwd_port.sv
// One store-to-load forwarding check port.
// Scans the age window [head, marker) oldest to youngest so the youngest
// word-address match with overlapping bytes wins.
//   ld_vld_i/ld_addr_i/ld_size_i/ld_marker_i : load request and tail snapshot
//   head_i, state_i, addr_i, data_i, size_i  : queue state from the top
//   hit_o / stall_o / data_o                 : forward result
// Build option SFQ_UNKNOWN_ADDR_SPEC_EN: ALLOC entries (unknown address) are
// ignored instead of forcing a stall.
module sfq_fwd_port
  import lsu_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned XLEN  = 32,
  localparam int unsigned IDXW = idx_width(DEPTH)
) (
  input  logic            ld_vld_i,
  input  logic [XLEN-1:0] ld_addr_i,
  input  logic [1:0]      ld_size_i,
  input  logic [IDXW:0]   ld_marker_i,
  input  logic [IDXW:0]   head_i,
  input  sq_state_e       state_i [DEPTH],
  input  logic [XLEN-1:0] addr_i  [DEPTH],
  input  logic [XLEN-1:0] data_i  [DEPTH],
  input  logic [1:0]      size_i  [DEPTH],
  output logic            hit_o,
  output logic            stall_o,
  output logic [XLEN-1:0] data_o
);

  logic [IDXW:0]   win_len;
  logic [IDXW-1:0] idx;
  logic            found;
  logic            unknown;
  logic            covered;
  logic [3:0]      ld_be;
  logic [3:0]      st_be;
  logic [3:0]      sel_be;
  logic [1:0]      sel_lo;
  logic [XLEN-1:0] sel_data;
  logic [XLEN-1:0] lane_data;
  logic [XLEN-1:0] extracted;
  logic [XLEN-1:0] size_mask;

  always_comb begin
    win_len  = ld_marker_i - head_i;
    ld_be    = size_to_be(ld_addr_i[1:0], ld_size_i);
    found    = 1'b0;
    unknown  = 1'b0;
    sel_be   = '0;
    sel_lo   = '0;
    sel_data = '0;
    idx      = '0;
    st_be    = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = head_i[IDXW-1:0] + IDXW'(k);
      if ((IDXW+1)'(k) < win_len) begin
        st_be = size_to_be(addr_i[idx][1:0], size_i[idx]);
        if (state_i[idx] == SQ_ALLOC) begin
`ifndef SFQ_UNKNOWN_ADDR_SPEC_EN
          unknown = 1'b1;
`endif
        end else if (state_i[idx] != SQ_FREE &&
                     addr_i[idx][XLEN-1:2] == ld_addr_i[XLEN-1:2] &&
                     (st_be & ld_be) != 4'b0000) begin
          found    = 1'b1;
          sel_be   = st_be;
          sel_lo   = addr_i[idx][1:0];
          sel_data = data_i[idx];
        end
      end
    end
  end

  always_comb begin
    lane_data = sel_data << {sel_lo, 3'b000};
    extracted = lane_data >> {ld_addr_i[1:0], 3'b000};
    case (ld_size_i)
      MEM_B:   size_mask = XLEN'(8'hFF);
      MEM_H:   size_mask = XLEN'(16'hFFFF);
      default: size_mask = '1;
    endcase
    covered = (sel_be & ld_be) == ld_be;
    hit_o   = ld_vld_i & found & covered & ~unknown;
    stall_o = ld_vld_i & (unknown | (found & ~covered));
    data_o  = hit_o ? (extracted & size_mask) : '0;
  end

endmodule

// File: rtl/store_forward_queue.sv
// Store data queue with in-order drain and multi-port store-to-load forwarding.
//   clk_i, rst_i (async, active-low)
//   disp_*      : allocate at tail; sdq_alloc_idx_o is tail incl. wrap bit
//   exec_*      : address/data arrival for an ALLOC entry
//   cmit_vld_i  : commit oldest uncommitted (READY) entry
//   flush_i     : drop all uncommitted entries, committed ones keep draining
//   issue_*     : valid/ready drain of committed head entry, lane-aligned
//   ld_*        : NUM_LD_PORTS combinational forwarding checks
// Build option SFQ_UNKNOWN_ADDR_SPEC_EN: loads bypass unknown-address stores.
module store_forward_queue
  import lsu_pkg::*;
#(
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned XLEN         = 32,
  parameter int unsigned NUM_LD_PORTS = 2,
  localparam int unsigned IDXW        = idx_width(DEPTH)
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           disp_vld_i,
  input  logic [1:0]                     disp_size_i,
  output logic [IDXW:0]                  sdq_alloc_idx_o,
  output logic                           sdq_full_o,
  input  logic                           exec_vld_i,
  input  logic [IDXW-1:0]                exec_idx_i,
  input  logic [XLEN-1:0]                exec_addr_i,
  input  logic [XLEN-1:0]                exec_data_i,
  input  logic                           cmit_vld_i,
  input  logic                           flush_i,
  output logic                           issue_vld_o,
  input  logic                           issue_rdy_i,
  output logic [XLEN-1:0]                issue_addr_o,
  output logic [XLEN-1:0]                issue_data_o,
  output logic [XLEN/8-1:0]              issue_be_o,
  input  logic [NUM_LD_PORTS-1:0]        ld_vld_i,
  input  logic [NUM_LD_PORTS*XLEN-1:0]   ld_addr_i,
  input  logic [NUM_LD_PORTS*2-1:0]      ld_size_i,
  input  logic [NUM_LD_PORTS*(IDXW+1)-1:0] ld_sdq_marker_i,
  output logic [NUM_LD_PORTS-1:0]        ld_hit_o,
  output logic [NUM_LD_PORTS-1:0]        ld_stall_o,
  output logic [NUM_LD_PORTS*XLEN-1:0]   ld_data_o
);

  localparam int unsigned BW = XLEN / 8;

  sq_state_e       state_q [DEPTH];
  sq_state_e       state_d [DEPTH];
  logic [XLEN-1:0] addr_q  [DEPTH];
  logic [XLEN-1:0] data_q  [DEPTH];
  logic [1:0]      size_q  [DEPTH];
  logic [IDXW:0]   head_q, head_d, cptr_q, cptr_d, tail_q, tail_d;

  logic [IDXW-1:0] head_idx, cptr_idx, tail_idx;
  logic            full, issue_vld;
  logic            do_disp, do_exec, do_cmt, do_drain;
  logic [1:0]      head_lo;

  assign head_idx  = head_q[IDXW-1:0];
  assign cptr_idx  = cptr_q[IDXW-1:0];
  assign tail_idx  = tail_q[IDXW-1:0];
  assign full      = (tail_q - head_q) == (IDXW+1)'(DEPTH);
  assign issue_vld = state_q[head_idx] == SQ_CMT;
  assign do_disp   = disp_vld_i & ~full & ~flush_i;
  assign do_exec   = exec_vld_i & (state_q[exec_idx_i] == SQ_ALLOC);
  assign do_cmt    = cmit_vld_i & (state_q[cptr_idx] == SQ_READY);
  assign do_drain  = issue_vld & issue_rdy_i;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    cptr_d  = cptr_q;
    tail_d  = tail_q;
    if (do_exec) state_d[exec_idx_i] = SQ_READY;
    if (do_cmt) begin
      state_d[cptr_idx] = SQ_CMT;
      cptr_d            = cptr_q + (IDXW+1)'(1);
    end
    if (do_drain) begin
      state_d[head_idx] = SQ_FREE;
      head_d            = head_q + (IDXW+1)'(1);
    end
    // Everything not committed (after this cycle's commit) is by construction
    // in [cptr_d, tail) or already FREE, so clearing non-CMT entries suffices.
    if (flush_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (state_d[i] != SQ_CMT) state_d[i] = SQ_FREE;
      end
      tail_d = cptr_d;
    end else if (do_disp) begin
      state_d[tail_idx] = SQ_ALLOC;
      tail_d            = tail_q + (IDXW+1)'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      head_q <= '0;
      cptr_q <= '0;
      tail_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        state_q[i] <= SQ_FREE;
        addr_q[i]  <= '0;
        data_q[i]  <= '0;
        size_q[i]  <= '0;
      end
    end else begin
      head_q <= head_d;
      cptr_q <= cptr_d;
      tail_q <= tail_d;
      for (int unsigned i = 0; i < DEPTH; i++) state_q[i] <= state_d[i];
      if (do_disp) size_q[tail_idx] <= disp_size_i;
      if (do_exec) begin
        addr_q[exec_idx_i] <= exec_addr_i;
        data_q[exec_idx_i] <= exec_data_i;
      end
    end
  end

  cmt_only_ready: assert property (@(posedge clk_i) disable iff (!rst_i)
    cmit_vld_i |-> state_q[cptr_idx] == SQ_READY);

  assign sdq_alloc_idx_o = tail_q;
  assign sdq_full_o      = full;
  assign head_lo         = addr_q[head_idx][1:0];
  assign issue_vld_o     = issue_vld;
  assign issue_addr_o    = issue_vld ? {addr_q[head_idx][XLEN-1:2], 2'b00} : '0;
  assign issue_data_o    = issue_vld ? (data_q[head_idx] << {head_lo, 3'b000}) : '0;
  assign issue_be_o      = issue_vld ? BW'(size_to_be(head_lo, size_q[head_idx])) : '0;

  for (genvar p = 0; p < NUM_LD_PORTS; p++) begin : g_ld
    sfq_fwd_port #(
      .DEPTH (DEPTH),
      .XLEN  (XLEN)
    ) u_fwd (
      .ld_vld_i    (ld_vld_i[p]),
      .ld_addr_i   (ld_addr_i[p*XLEN +: XLEN]),
      .ld_size_i   (ld_size_i[p*2 +: 2]),
      .ld_marker_i (ld_sdq_marker_i[p*(IDXW+1) +: IDXW+1]),
      .head_i      (head_q),
      .state_i     (state_q),
      .addr_i      (addr_q),
      .data_i      (data_q),
      .size_i      (size_q),
      .hit_o       (ld_hit_o[p]),
      .stall_o     (ld_stall_o[p]),
      .data_o      (ld_data_o[p*XLEN +: XLEN])
    );
  end

endmodule

// File: tb/tb_store_forward_queue.sv
`timescale 1ns/1ps
module tb_store_forward_queue;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned NP    = 2;
  localparam logic [1:0] SZ_B = 2'b00, SZ_H = 2'b01, SZ_W = 2'b10;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        disp_vld_i;
  logic [1:0]  disp_size_i;
  logic [3:0]  sdq_alloc_idx_o;
  logic        sdq_full_o;
  logic        exec_vld_i;
  logic [2:0]  exec_idx_i;
  logic [31:0] exec_addr_i, exec_data_i;
  logic        cmit_vld_i, flush_i;
  logic        issue_vld_o, issue_rdy_i;
  logic [31:0] issue_addr_o, issue_data_o;
  logic [3:0]  issue_be_o;
  logic [1:0]  ld_vld_i;
  logic [63:0] ld_addr_i;
  logic [3:0]  ld_size_i;
  logic [7:0]  ld_sdq_marker_i;
  logic [1:0]  ld_hit_o, ld_stall_o;
  logic [63:0] ld_data_o;

  store_forward_queue #(.DEPTH(DEPTH), .XLEN(XLEN), .NUM_LD_PORTS(NP)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .disp_vld_i(disp_vld_i), .disp_size_i(disp_size_i),
    .sdq_alloc_idx_o(sdq_alloc_idx_o), .sdq_full_o(sdq_full_o),
    .exec_vld_i(exec_vld_i), .exec_idx_i(exec_idx_i),
    .exec_addr_i(exec_addr_i), .exec_data_i(exec_data_i),
    .cmit_vld_i(cmit_vld_i), .flush_i(flush_i),
    .issue_vld_o(issue_vld_o), .issue_rdy_i(issue_rdy_i),
    .issue_addr_o(issue_addr_o), .issue_data_o(issue_data_o), .issue_be_o(issue_be_o),
    .ld_vld_i(ld_vld_i), .ld_addr_i(ld_addr_i), .ld_size_i(ld_size_i),
    .ld_sdq_marker_i(ld_sdq_marker_i),
    .ld_hit_o(ld_hit_o), .ld_stall_o(ld_stall_o), .ld_data_o(ld_data_o)
  );

  always #5 clk_i = ~clk_i;

  int unsigned total = 0;
  int unsigned bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } issue_t;

  issue_t      exp_q[$];
  logic [31:0] s_addr [DEPTH];
  logic [31:0] s_data [DEPTH];
  logic [1:0]  s_size [DEPTH];

  function automatic issue_t mk_issue(input logic [31:0] a, input logic [31:0] d,
                                      input logic [1:0] sz);
    issue_t r;
    logic [3:0] m;
    case (sz)
      SZ_B:    m = 4'h1;
      SZ_H:    m = 4'h3;
      default: m = 4'hF;
    endcase
    r.addr = {a[31:2], 2'b00};
    r.data = d << (8 * a[1:0]);
    r.be   = m << a[1:0];
    return r;
  endfunction

  // Drain monitor: a handshake seen at the negedge completes on the next posedge.
  always @(negedge clk_i) begin
    if (rst_i && issue_vld_o && issue_rdy_i) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_issue: got addr 0x%0h data 0x%0h, expected no issue",
                 issue_addr_o, issue_data_o);
      end else begin
        issue_t e;
        e = exp_q.pop_front();
        chk("issue_addr", issue_addr_o, e.addr);
        chk("issue_data", issue_data_o, e.data);
        chk("issue_be", issue_be_o, e.be);
      end
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_inputs();
    disp_vld_i = 0; disp_size_i = 0; exec_vld_i = 0; exec_idx_i = 0;
    exec_addr_i = 0; exec_data_i = 0; cmit_vld_i = 0; flush_i = 0;
    issue_rdy_i = 0; ld_vld_i = 0; ld_addr_i = 0; ld_size_i = 0; ld_sdq_marker_i = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_i = 0;
    step();
    step();
    exp_q.delete();
    rst_i = 1;
    step();
  endtask

  task automatic disp(input logic [1:0] sz);
    disp_vld_i = 1; disp_size_i = sz;
    step();
    disp_vld_i = 0;
  endtask

  task automatic exec(input int unsigned idx, input logic [31:0] a, input logic [31:0] d,
                      input logic [1:0] sz);
    exec_vld_i = 1; exec_idx_i = 3'(idx); exec_addr_i = a; exec_data_i = d;
    s_addr[idx] = a; s_data[idx] = d; s_size[idx] = sz;
    step();
    exec_vld_i = 0;
  endtask

  task automatic commit(input int unsigned idx);
    exp_q.push_back(mk_issue(s_addr[idx], s_data[idx], s_size[idx]));
    cmit_vld_i = 1;
    step();
    cmit_vld_i = 0;
  endtask

  task automatic drain_all(input string name);
    issue_rdy_i = 1;
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) step();
    repeat (3) step();
    issue_rdy_i = 0;
    chk(name, 64'(exp_q.size()), 64'd0);
  endtask

  typedef struct {
    logic        vld;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [3:0]  marker;
    logic        hit;
    logic        stall;
    logic [31:0] data;
  } fwd_vec_t;

  function automatic fwd_vec_t fv(input logic v, input logic [31:0] a, input logic [1:0] s,
                                  input logic [3:0] m, input logic h, input logic st,
                                  input logic [31:0] d);
    fwd_vec_t r;
    r.vld = v; r.addr = a; r.size = s; r.marker = m; r.hit = h; r.stall = st; r.data = d;
    return r;
  endfunction

  fwd_vec_t vt [16];

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    clear_inputs();
    // Reset values while reset is held
    step();
    step();
    chk("rst_full", sdq_full_o, 0);
    chk("rst_alloc_idx", sdq_alloc_idx_o, 0);
    chk("rst_issue_vld", issue_vld_o, 0);
    chk("rst_issue_be", issue_be_o, 0);
    chk("rst_ld_hit", ld_hit_o, 0);
    chk("rst_ld_stall", ld_stall_o, 0);
    rst_i = 1;
    step();

    // Reset with three entries allocated
    repeat (3) disp(SZ_W);
    chk("pre_rst_alloc_idx", sdq_alloc_idx_o, 3);
    rst_i = 0;
    step();
    chk("midrst_full", sdq_full_o, 0);
    chk("midrst_alloc_idx", sdq_alloc_idx_o, 0);
    chk("midrst_issue_vld", issue_vld_o, 0);
    rst_i = 1;
    step();

    // Fill, overflow, drain one, wrap
    repeat (DEPTH) disp(SZ_W);
    chk("fill_full", sdq_full_o, 1);
    chk("fill_alloc_idx", sdq_alloc_idx_o, 4'h8);
    disp(SZ_W);
    chk("ninth_ignored_idx", sdq_alloc_idx_o, 4'h8);
    chk("ninth_ignored_full", sdq_full_o, 1);
    exec(0, 32'h40, 32'h1234_5678, SZ_W);
    chk("ready_not_issued", issue_vld_o, 0);
    commit(0);
    chk("cmt_issue_vld", issue_vld_o, 1);
    issue_rdy_i = 1;
    step();
    issue_rdy_i = 0;
    chk("after_drain_full", sdq_full_o, 0);
    chk("after_drain_idx", sdq_alloc_idx_o, 4'h8);
    disp(SZ_W);
    chk("wrap_alloc_idx", sdq_alloc_idx_o, 4'h9);
    chk("wrap_full", sdq_full_o, 1);
    chk("wrap_queue_empty", 64'(exp_q.size()), 64'd0);

    // Forwarding table
    do_reset();
    disp(SZ_W); disp(SZ_B); disp(SZ_W); disp(SZ_W); disp(SZ_H); disp(SZ_W);
    exec(0, 32'h100, 32'hDEAD_BEEF, SZ_W);
    exec(1, 32'h200, 32'h11, SZ_B);
    exec(2, 32'h300, 32'hAAAA_AAAA, SZ_W);
    exec(3, 32'h300, 32'hBBBB_BBBB, SZ_W);
    exec(4, 32'h402, 32'h5566, SZ_H);

    vt[0]  = fv(1, 32'h102, SZ_B, 1, 1, 0, 32'hAD);
    vt[1]  = fv(1, 32'h100, SZ_W, 1, 1, 0, 32'hDEAD_BEEF);
    vt[2]  = fv(1, 32'h102, SZ_H, 1, 1, 0, 32'hDEAD);
    vt[3]  = fv(1, 32'h200, SZ_W, 2, 0, 1, 0);
    vt[4]  = fv(1, 32'h200, SZ_B, 2, 1, 0, 32'h11);
    vt[5]  = fv(1, 32'h201, SZ_B, 2, 0, 0, 0);
    vt[6]  = fv(1, 32'h300, SZ_W, 3, 1, 0, 32'hAAAA_AAAA);
    vt[7]  = fv(1, 32'h300, SZ_W, 4, 1, 0, 32'hBBBB_BBBB);
    vt[8]  = fv(1, 32'h100, SZ_W, 0, 0, 0, 0);
    vt[9]  = fv(1, 32'h403, SZ_B, 5, 1, 0, 32'h55);
    vt[10] = fv(1, 32'h400, SZ_W, 5, 0, 1, 0);
    vt[11] = fv(1, 32'h600, SZ_W, 5, 0, 0, 0);
    vt[12] = fv(0, 32'h102, SZ_B, 1, 0, 0, 0);
    vt[13] = fv(1, 32'h302, SZ_H, 4, 1, 0, 32'hBBBB);
`ifdef SFQ_UNKNOWN_ADDR_SPEC_EN
    vt[14] = fv(1, 32'h500, SZ_W, 6, 0, 0, 0);
    vt[15] = fv(1, 32'h102, SZ_B, 6, 1, 0, 32'hAD);
`else
    vt[14] = fv(1, 32'h500, SZ_W, 6, 0, 1, 0);
    vt[15] = fv(1, 32'h102, SZ_B, 6, 0, 1, 0);
`endif

    for (int i = 0; i < 16; i++) begin
      int p;
      int q;
      p = i % 2;
      q = 1 - p;
      ld_vld_i = 0; ld_addr_i = 0; ld_size_i = 0; ld_sdq_marker_i = 0;
      ld_vld_i[p] = vt[i].vld;
      ld_addr_i[p*32 +: 32] = vt[i].addr;
      ld_size_i[p*2 +: 2] = vt[i].size;
      ld_sdq_marker_i[p*4 +: 4] = vt[i].marker;
      #1;
      chk($sformatf("fwd%0d_hit", i), ld_hit_o[p], vt[i].hit);
      chk($sformatf("fwd%0d_stall", i), ld_stall_o[p], vt[i].stall);
      chk($sformatf("fwd%0d_data", i), ld_data_o[p*32 +: 32], vt[i].data);
      chk($sformatf("fwd%0d_idle_port", i),
          {ld_hit_o[q], ld_stall_o[q], ld_data_o[q*32 +: 32]}, 0);
    end

    // Concurrent ports with different age markers
    ld_vld_i = 2'b11;
    ld_addr_i = {32'h300, 32'h300};
    ld_size_i = {SZ_W, SZ_W};
    ld_sdq_marker_i = {4'd4, 4'd3};
    #1;
    chk("dual_hit", ld_hit_o, 2'b11);
    chk("dual_p0_data", ld_data_o[31:0], 32'hAAAA_AAAA);
    chk("dual_p1_data", ld_data_o[63:32], 32'hBBBB_BBBB);
    ld_vld_i = 0;
    step();

    // Drain lane-aligned committed stores; the ALLOC entry stays behind
    for (int i = 0; i < 5; i++) commit(i);
    drain_all("fwd_drain_done");
    chk("fwd_drain_stop", issue_vld_o, 0);

    // Commit two of four, flush with a same-cycle commit and dropped dispatch
    do_reset();
    repeat (4) disp(SZ_W);
    for (int i = 0; i < 4; i++) exec(i, 32'h700 + 32'(4 * i), 32'hC0DE_0000 + 32'(i), SZ_W);
    commit(0);
    exp_q.push_back(mk_issue(s_addr[1], s_data[1], s_size[1]));
    cmit_vld_i = 1; flush_i = 1; disp_vld_i = 1; disp_size_i = SZ_W;
    step();
    cmit_vld_i = 0; flush_i = 0; disp_vld_i = 0;
    chk("flush_tail_eq_cptr", sdq_alloc_idx_o, 4'd2);
    chk("flush_full", sdq_full_o, 0);
    drain_all("flush_drain_done");
    chk("flush_no_more_issue", issue_vld_o, 0);
    chk("flush_tail_stable", sdq_alloc_idx_o, 4'd2);
    disp(SZ_W);
    chk("post_flush_alloc", sdq_alloc_idx_o, 4'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
